// File: rtl/skein_nonce_scanner.sv
// Drives a nonce range into the skein512 core at one nonce per two clocks, compares each
// returned hash against a 64-bit target and queues winning nonces for the host.
module skein_nonce_scanner #(
  parameter int NONCE_LAG  = 56,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic [31:0]  nonce,
  input  logic [511:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  input  logic         found_ready,
  output logic         overflow
);
  localparam int LAG_W = $clog2(NONCE_LAG + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LAG_W-1:0] LAG_FULL = LAG_W'(NONCE_LAG);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               phase;
  logic [31:0]        issue_ctr, check_ctr, end_nonce;
  logic [63:0]        tgt;
  logic [LAG_W-1:0]   issued;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [PTR_W:0]     count;
  logic [63:0]        metric;
  logic               accept, active, slot, issue, check, win, full, pop, push, drop;
  logic               last_issue, last_check;
  logic               unused_hash_bits;

  assign accept     = (state == IDLE) && start;
  assign active     = (state == SCAN) || (state == DRAIN);
  // Every phase==1 cycle is a core slot; in DRAIN the core re-hashes the held nonce.
  assign slot       = active && phase;
  assign issue      = slot && (state == SCAN);
  assign check      = slot && (issued == LAG_FULL);
  assign metric     = hash_in[511:448];
  assign win        = check && (metric <= tgt);
  assign full       = (count == CNT_FULL);
  assign pop        = found_valid && found_ready;
  assign push       = win && (!full || pop);
  assign drop       = win && full && !pop;
  assign last_issue = issue && (issue_ctr == end_nonce);
  assign last_check = check && (check_ctr == end_nonce);
  assign found_valid = (count != '0);
  assign rd_nxt     = rd_ptr + 1'b1;
  assign unused_hash_bits = ^hash_in[447:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_check)      state_nxt = DONE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_check) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= 1'b0;
      issued    <= '0;
      issue_ctr <= '0;
      check_ctr <= '0;
      end_nonce <= '0;
      tgt       <= '0;
      nonce     <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      phase     <= 1'b0;
      issued    <= '0;
      issue_ctr <= nonce_start;
      check_ctr <= nonce_start;
      end_nonce <= nonce_end;
      tgt       <= target;
      overflow  <= 1'b0;
    end else begin
      if (active) phase <= ~phase;
      if (slot && (issued != LAG_FULL)) issued <= issued + 1'b1;
      if (issue) begin
        nonce     <= issue_ctr;
        issue_ctr <= issue_ctr + 32'd1;
      end
      if (check) check_ctr <= check_ctr + 32'd1;
      if (drop)  overflow  <= 1'b1;
    end
  end

  // found_nonce is a registered copy of the FIFO head, forwarded from the push when needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      found_nonce <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop) begin
        if (count != CNT_ONE) found_nonce <= mem[rd_nxt];
        else if (push)        found_nonce <= check_ctr;
      end else if (!found_valid && push) begin
        found_nonce <= check_ctr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= check_ctr;
  end

endmodule

// File: tb/tb_skein_nonce_scanner.sv
// Bench for skein_nonce_scanner: a delay-line model of the skein512 core feeds hash_in and a
// scoreboard queue holds the winning nonces expected at the host port.
module tb_skein_nonce_scanner;
  localparam int NONCE_LAG  = 56;
  localparam int FIFO_DEPTH = 4;
  localparam int CORE_DLY   = 2 * NONCE_LAG;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         found_ready = 1'b0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [63:0]  target = '0;
  logic [31:0]  nonce, found_nonce;
  logic [511:0] hash_in;
  logic         busy, done, found_valid, overflow;

  int mode = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] seen_q[$];
  logic [31:0] hist [CORE_DLY];

  skein_nonce_scanner #(.NONCE_LAG(NONCE_LAG), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .nonce_start(nonce_start),
    .nonce_end(nonce_end), .target(target), .nonce(nonce), .hash_in(hash_in),
    .busy(busy), .done(done), .found_valid(found_valid), .found_nonce(found_nonce),
    .found_ready(found_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Core model: the hash of a nonce issued on a slot edge is on hash_in NONCE_LAG slots later.
  always @(negedge clk) begin
    for (int i = CORE_DLY - 1; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= nonce;
  end

  function automatic logic [511:0] core_hash(input logic [31:0] n, input int m);
    logic [63:0] metric;
    case (m)
      1:       metric = (n == 32'h25) ? 64'h0 : {32'h8000_0000 ^ n, n};
      2:       metric = {32'h0, n};
      default: metric = {~n, n};
    endcase
    return {metric, {14{~n}}};
  endfunction

  assign hash_in = core_hash(hist[CORE_DLY-1], mode);

  task automatic run_scan(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t,
                          input int m, input logic rdy, input int restart_at,
                          output int dones, output bit tmo, output logic ovf0);
    int after;
    logic [31:0] prev;
    got_q.delete();
    seen_q.delete();
    mode = m;
    found_ready = rdy;
    nonce_start = s; nonce_end = e; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ovf0 = overflow;
    prev = nonce;
    dones = 0;
    after = -1;
    for (int c = 0; c < 4000 && after != 0; c++) begin
      if (nonce !== prev) begin seen_q.push_back(nonce); prev = nonce; end
      if (found_valid && found_ready) got_q.push_back(found_nonce);
      if (done) begin dones++; if (after < 0) after = 12; end
      if (after > 0) after--;
      if (c == restart_at) begin
        nonce_start = 32'hA0; nonce_end = 32'hA1; target = 64'h0; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    tmo = (after != 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (nonce !== 32'h0) begin n_err++; $display("FAIL reset_nonce got=%h want=0", nonce); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (found_valid !== 1'b0) begin n_err++; $display("FAIL reset_found_valid got=%b want=0", found_valid); end
    n_cmp++; if (found_nonce !== 32'h0) begin n_err++; $display("FAIL reset_found_nonce got=%h want=0", found_nonce); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_win();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
    run_scan(32'h10, 32'h13, '1, 0, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL all_win_timeout got=no_done want=done"); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL all_win_dones got=%0d want=1", dones); end
    n_cmp++; if (seen_q.size() != 4) begin n_err++; $display("FAIL all_win_issued got=%0d want=4", seen_q.size()); end
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      n_cmp++; if (seen_q[i] !== 32'h10 + i) begin n_err++; $display("FAIL all_win_core_nonce got=%h want=%h", seen_q[i], 32'h10 + i); end
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL all_win_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL all_win_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
  endtask

  task automatic test_single_win();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    exp_q.push_back(32'h25);
    run_scan(32'h20, 32'h2F, 64'h0, 1, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL single_win_done got=%0d want=1", dones); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_win_overflow got=%b want=0", overflow); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_win_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL single_win_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
  endtask

  task automatic test_target_boundary();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    for (int n = 32'h30; n <= 32'h37; n++) if (n <= 32'h33) exp_q.push_back(32'(n));
    run_scan(32'h30, 32'h37, 64'h33, 2, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL boundary_done got=%0d want=1", dones); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL boundary_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL boundary_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
  endtask

  task automatic test_single_nonce();
    int dones; bit tmo; logic ovf0;
    run_scan(32'h40, 32'h40, '1, 0, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL one_nonce_done got=%0d want=1", dones); end
    n_cmp++; if (seen_q.size() != 1 || seen_q[0] !== 32'h40) begin n_err++; $display("FAIL one_nonce_issued got=%0d want=1", seen_q.size()); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h40) begin n_err++; $display("FAIL one_nonce_found got=%0d want=1", got_q.size()); end
  endtask

  task automatic test_wrap();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0; want[3] = 32'h1;
    for (int i = 0; i < 4; i++) exp_q.push_back(want[i]);
    run_scan(32'hFFFF_FFFE, 32'h0000_0001, '1, 0, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL wrap_done got=%0d want=1", dones); end
    n_cmp++; if (seen_q.size() != 4) begin n_err++; $display("FAIL wrap_issued got=%0d want=4", seen_q.size()); end
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      n_cmp++; if (seen_q[i] !== want[i]) begin n_err++; $display("FAIL wrap_core_nonce got=%h want=%h", seen_q[i], want[i]); end
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL wrap_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL wrap_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    for (int i = 0; i < FIFO_DEPTH; i++) exp_q.push_back(32'h50 + i);
    run_scan(32'h50, 32'h55, '1, 0, 1'b0, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL ovf_done got=%0d want=1", dones); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    n_cmp++; if (found_valid !== 1'b1 || found_nonce !== 32'h50) begin n_err++; $display("FAIL ovf_head got=%b/%h want=1/00000050", found_valid, found_nonce); end
    found_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (found_valid) got_q.push_back(found_nonce);
      @(negedge clk);
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL ovf_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
    n_cmp++; if (found_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b want=0", found_valid); end
    run_scan(32'h60, 32'h61, 64'h0, 1, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_start got=%b want=0", ovf0); end
    n_cmp++; if (tmo || dones != 1 || got_q.size() != 0) begin n_err++; $display("FAIL ovf_next_scan got=%0d/%0d want=1/0", dones, got_q.size()); end
  endtask

  task automatic test_reset_mid_scan();
    int dones, stray; bit tmo; logic ovf0;
    mode = 0; found_ready = 1'b1;
    nonce_start = 32'h70; nonce_end = 32'h7F; target = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (nonce !== 32'h0) begin n_err++; $display("FAIL midrst_nonce got=%h want=0", nonce); end
    n_cmp++; if (found_valid !== 1'b0 || found_nonce !== 32'h0 || overflow !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL midrst_outputs got=%b%h%b%b want=0000000000", found_valid, found_nonce, overflow, done); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 200; c++) begin
      if (done || busy) stray++;
      @(negedge clk);
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL midrst_no_done got=%0d want=0", stray); end
    exp_q.push_back(32'h80); exp_q.push_back(32'h81);
    run_scan(32'h80, 32'h81, '1, 0, 1'b1, -1, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL midrst_rescan_done got=%0d want=1", dones); end
    n_cmp++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
      begin n_err++; $display("FAIL midrst_rescan_found got=%0d want=2", got_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_start_during_scan();
    int dones; bit tmo; logic ovf0; logic [31:0] w, g;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h90 + i);
    run_scan(32'h90, 32'h93, '1, 0, 1'b1, 20, dones, tmo, ovf0);
    n_cmp++; if (tmo || dones != 1) begin n_err++; $display("FAIL restart_done got=%0d want=1", dones); end
    n_cmp++; if (seen_q.size() != 4) begin n_err++; $display("FAIL restart_issued got=%0d want=4", seen_q.size()); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL restart_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== w) begin n_err++; $display("FAIL restart_found got=%h want=%h", g, w); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_all_win();
    test_single_win();
    test_target_boundary();
    test_single_nonce();
    test_wrap();
    test_overflow();
    test_reset_mid_scan();
    test_start_during_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
